// File: rtl/pcss_top.sv
// pcss_top: one PCSS tile with four parity-protected four-phase links, a packet router and a tik-driven spike fan-out table.
// Build option PCSS_PARITY_EN: receive parity checking and send parity generation (otherwise both tied off).
module pcss_top #(
    parameter int FW             = 59,
    parameter int B              = 4,
    parameter int CONNECT        = 2,
    parameter int CONNECT_WIDTH  = 5,
    parameter int P_MESH         = 5,
    parameter int P_HIER         = 7,
    parameter int CHIPDATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tik,
    input  logic [CHIPDATA_WIDTH-1:0] recv_data_in_E,
    input  logic                      recv_data_valid_E,
    input  logic                      recv_data_par_E,
    output logic                      recv_data_ready_E,
    output logic                      recv_data_err_E,
    input  logic [CHIPDATA_WIDTH-1:0] recv_data_in_N,
    input  logic                      recv_data_valid_N,
    input  logic                      recv_data_par_N,
    output logic                      recv_data_ready_N,
    output logic                      recv_data_err_N,
    input  logic [CHIPDATA_WIDTH-1:0] recv_data_in_W,
    input  logic                      recv_data_valid_W,
    input  logic                      recv_data_par_W,
    output logic                      recv_data_ready_W,
    output logic                      recv_data_err_W,
    input  logic [CHIPDATA_WIDTH-1:0] recv_data_in_S,
    input  logic                      recv_data_valid_S,
    input  logic                      recv_data_par_S,
    output logic                      recv_data_ready_S,
    output logic                      recv_data_err_S,
    output logic [CHIPDATA_WIDTH-1:0] send_data_out_E,
    output logic                      send_data_valid_E,
    output logic                      send_data_par_E,
    input  logic                      send_data_ready_E,
    input  logic                      send_data_err_E,
    output logic [CHIPDATA_WIDTH-1:0] send_data_out_N,
    output logic                      send_data_valid_N,
    output logic                      send_data_par_N,
    input  logic                      send_data_ready_N,
    input  logic                      send_data_err_N,
    output logic [CHIPDATA_WIDTH-1:0] send_data_out_W,
    output logic                      send_data_valid_W,
    output logic                      send_data_par_W,
    input  logic                      send_data_ready_W,
    input  logic                      send_data_err_W,
    output logic [CHIPDATA_WIDTH-1:0] send_data_out_S,
    output logic                      send_data_valid_S,
    output logic                      send_data_par_S,
    input  logic                      send_data_ready_S,
    input  logic                      send_data_err_S
);
    localparam int PW = FW + CONNECT_WIDTH;
    localparam int DW = CHIPDATA_WIDTH;
    localparam int N  = 1 << B;

    // Connection and port counts are placeholders for larger meshes.
    if (CONNECT < 0 || P_MESH < 0 || P_HIER < 0) begin : g_reserved
    end

    // Link handshake (both directions): a word is transferred when valid and ready are both 1;
    // ready then stays 1 until valid drops, and the next word may only start once ready is back at 0.
    // Port index 0..3 = E, N, W, S, which is also route code minus one.
    logic [DW-1:0] rx_in [4];
    logic [3:0]    rx_valid, rx_par, tx_ready, tx_err;
    logic [3:0]    rx_ready, rx_err, rx_full, rx_bad;
    logic [1:0]    rx_cnt [4];
    logic [PW-1:0] rx_asm [4];
    logic [3:0]    rx_tgt [4];

    logic [3:0]    tx_busy, tx_valid, tx_wait, tx_load, tx_par;
    logic [1:0]    tx_cnt [4];
    logic [PW-1:0] tx_buf [4];
    logic [DW-1:0] tx_data [4];

    assign rx_in[0] = recv_data_in_E;
    assign rx_in[1] = recv_data_in_N;
    assign rx_in[2] = recv_data_in_W;
    assign rx_in[3] = recv_data_in_S;
    assign rx_valid = {recv_data_valid_S, recv_data_valid_W, recv_data_valid_N, recv_data_valid_E};
    assign rx_par   = {recv_data_par_S, recv_data_par_W, recv_data_par_N, recv_data_par_E};
    assign tx_ready = {send_data_ready_S, send_data_ready_W, send_data_ready_N, send_data_ready_E};
    assign tx_err   = {send_data_err_S, send_data_err_W, send_data_err_N, send_data_err_E};

    assign {recv_data_ready_S, recv_data_ready_W, recv_data_ready_N, recv_data_ready_E} = rx_ready;
    assign {recv_data_err_S, recv_data_err_W, recv_data_err_N, recv_data_err_E}         = rx_err;
    assign {send_data_valid_S, send_data_valid_W, send_data_valid_N, send_data_valid_E} = tx_valid;
    assign {send_data_par_S, send_data_par_W, send_data_par_N, send_data_par_E}         = tx_par;
    assign send_data_out_E = tx_data[0];
    assign send_data_out_N = tx_data[1];
    assign send_data_out_W = tx_data[2];
    assign send_data_out_S = tx_data[3];

    // Send-buffer one-hot for a packet; zero for local, dropped kinds and bad routes.
    function automatic logic [3:0] fwd_tgt(input logic [PW-1:0] pkt);
        logic [3:0] t;
        t = 4'b0000;
        if (!pkt[PW-1]) begin
            case (pkt[PW-3:PW-5])
                3'd1:    t = 4'b0001;
                3'd2:    t = 4'b0010;
                3'd3:    t = 4'b0100;
                3'd4:    t = 4'b1000;
                default: t = 4'b0000;
            endcase
        end
        return t;
    endfunction

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            tx_data[p] = tx_valid[p] ? tx_buf[p][PW-1:PW-DW] : '0;
`ifdef PCSS_PARITY_EN
            rx_bad[p] = rx_par[p] != ^rx_in[p];
            tx_par[p] = ^tx_data[p];
`else
            rx_bad[p] = 1'b0;
            tx_par[p] = 1'b0;
`endif
            rx_tgt[p] = fwd_tgt(rx_asm[p]);
        end
    end

`ifndef PCSS_PARITY_EN
    logic unused_rx_par;
    assign unused_rx_par = ^rx_par;
`endif

    // Fan-out table: valid bits are reset, entry contents are not.
    logic [N-1:0]  tbl_v;
    logic [46:0]   fan_tbl [N];
    logic [N-1:0]  pending, work, spike_vec, gen_clr;
    logic          tik_q, tik_edge;

    logic          sel_valid, cfg_we, spike_we, gen_hit, gen_take;
    logic [PW-1:0] sel_pkt, gen_pkt, load_pkt;
    logic [3:0]    take_rx, gen_tgt;
    logic [B-1:0]  gen_idx;

    assign tik_edge = tik_q ^ tik;

    always_comb begin
        take_rx   = '0;
        sel_valid = 1'b0;
        sel_pkt   = '0;
        for (int p = 0; p < 4; p++) begin
            if (!sel_valid && rx_full[p] && (rx_tgt[p] & tx_busy) == 4'b0000) begin
                sel_valid  = 1'b1;
                take_rx[p] = 1'b1;
                sel_pkt    = rx_asm[p];
            end
        end
        cfg_we   = sel_valid && sel_pkt[PW-1:PW-5] == 5'b01000;
        spike_we = sel_valid && sel_pkt[PW-1:PW-5] == 5'b00000;

        gen_hit = 1'b0;
        gen_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (work[i]) begin
                gen_hit = 1'b1;
                gen_idx = i[B-1:0];
            end
        end
        gen_pkt  = {2'b00, fan_tbl[gen_idx][46:44], 15'b0, fan_tbl[gen_idx][43:0]};
        gen_tgt  = (gen_hit && tbl_v[gen_idx]) ? fwd_tgt(gen_pkt) : 4'b0000;
        gen_take = !sel_valid && gen_tgt != 4'b0000 && (gen_tgt & tx_busy) == 4'b0000;

        // Walk drops the current bit when it is offered successfully or cannot be offered at all.
        gen_clr = '0;
        gen_clr[gen_idx] = gen_hit && (gen_tgt == 4'b0000 || gen_take);
        spike_vec = '0;
        spike_vec[sel_pkt[B-1:0]] = spike_we;

        tx_load  = sel_valid ? fwd_tgt(sel_pkt) : (gen_take ? gen_tgt : 4'b0000);
        load_pkt = sel_valid ? {sel_pkt[PW-1:PW-2], 3'b000, sel_pkt[PW-6:0]} : gen_pkt;
    end

    always_ff @(posedge clk) begin
        if (cfg_we) fan_tbl[sel_pkt[B+47:48]] <= sel_pkt[46:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tik_q   <= 1'b0;
            tbl_v   <= '0;
            pending <= '0;
            work    <= '0;
        end else begin
            tik_q <= tik;
            if (cfg_we) tbl_v[sel_pkt[B+47:48]] <= sel_pkt[47];
            pending <= tik_edge ? spike_vec : (pending | spike_vec);
            work    <= (work & ~gen_clr) | (tik_edge ? pending : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready <= '0;
            rx_err   <= '0;
            rx_full  <= '0;
            for (int p = 0; p < 4; p++) begin
                rx_cnt[p] <= '0;
                rx_asm[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (take_rx[p]) rx_full[p] <= 1'b0;
                if (!rx_ready[p] && rx_valid[p] && !rx_full[p]) begin
                    rx_ready[p] <= 1'b1;
                    rx_err[p]   <= rx_bad[p];
                    if (rx_bad[p]) begin
                        rx_cnt[p] <= '0;
                    end else begin
                        rx_asm[p] <= {rx_asm[p][PW-DW-1:0], rx_in[p]};
                        rx_cnt[p] <= rx_cnt[p] + 2'd1;
                        if (rx_cnt[p] == 2'd3) rx_full[p] <= 1'b1;
                    end
                end else if (rx_ready[p] && !rx_valid[p]) begin
                    rx_ready[p] <= 1'b0;
                    rx_err[p]   <= 1'b0;
                end
            end
        end
    end

    // tx_wait: a handshake finished (or a packet was loaded); hold off until far-side ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= '0;
            tx_valid <= '0;
            tx_wait  <= '0;
            for (int p = 0; p < 4; p++) begin
                tx_cnt[p] <= '0;
                tx_buf[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (tx_load[p]) begin
                    tx_busy[p]  <= 1'b1;
                    tx_buf[p]   <= load_pkt;
                    tx_cnt[p]   <= '0;
                    tx_valid[p] <= 1'b0;
                    tx_wait[p]  <= 1'b1;
                end else if (tx_valid[p] && tx_ready[p]) begin
                    tx_valid[p] <= 1'b0;
                    tx_wait[p]  <= 1'b1;
                    if (!tx_err[p]) begin
                        tx_buf[p] <= tx_buf[p] << DW;
                        tx_cnt[p] <= tx_cnt[p] + 2'd1;
                        if (tx_cnt[p] == 2'd3) tx_busy[p] <= 1'b0;
                    end
                end else if (tx_wait[p] && !tx_ready[p]) begin
                    tx_wait[p]  <= 1'b0;
                    tx_valid[p] <= tx_busy[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_pcss_top.sv
// Bench for pcss_top: directed packets on the four links, a packet-level model of routing and fan-out,
// and one compare process acting as the far side of every send link.
module tb_pcss_top;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tik   = 1'b0;
    logic [15:0] rx_data [4];
    logic        rx_valid [4];
    logic        rx_par [4];
    logic        rx_ready [4];
    logic        rx_err [4];
    logic [15:0] tx_data [4];
    logic        tx_valid [4];
    logic        tx_par [4];
    logic        tx_ready [4];
    logic        tx_err [4];

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [4][$];
    logic [15:0] got_q [4][$];
    int          got_total [4];

    logic [47:0] m_tbl [16];
    bit          m_pend [16];

    int          inj_port = -1;
    int          inj_word = 0;
    bit          inj_armed = 1'b0;
    int          inj_hits = 0;
    logic [15:0] inj_seen = '0;

    pcss_top dut (
        .clk(clk), .rst_n(rst_n), .tik(tik),
        .recv_data_in_E(rx_data[0]), .recv_data_valid_E(rx_valid[0]), .recv_data_par_E(rx_par[0]),
        .recv_data_ready_E(rx_ready[0]), .recv_data_err_E(rx_err[0]),
        .recv_data_in_N(rx_data[1]), .recv_data_valid_N(rx_valid[1]), .recv_data_par_N(rx_par[1]),
        .recv_data_ready_N(rx_ready[1]), .recv_data_err_N(rx_err[1]),
        .recv_data_in_W(rx_data[2]), .recv_data_valid_W(rx_valid[2]), .recv_data_par_W(rx_par[2]),
        .recv_data_ready_W(rx_ready[2]), .recv_data_err_W(rx_err[2]),
        .recv_data_in_S(rx_data[3]), .recv_data_valid_S(rx_valid[3]), .recv_data_par_S(rx_par[3]),
        .recv_data_ready_S(rx_ready[3]), .recv_data_err_S(rx_err[3]),
        .send_data_out_E(tx_data[0]), .send_data_valid_E(tx_valid[0]), .send_data_par_E(tx_par[0]),
        .send_data_ready_E(tx_ready[0]), .send_data_err_E(tx_err[0]),
        .send_data_out_N(tx_data[1]), .send_data_valid_N(tx_valid[1]), .send_data_par_N(tx_par[1]),
        .send_data_ready_N(tx_ready[1]), .send_data_err_N(tx_err[1]),
        .send_data_out_W(tx_data[2]), .send_data_valid_W(tx_valid[2]), .send_data_par_W(tx_par[2]),
        .send_data_ready_W(tx_ready[2]), .send_data_err_W(tx_err[2]),
        .send_data_out_S(tx_data[3]), .send_data_valid_S(tx_valid[3]), .send_data_par_S(tx_par[3]),
        .send_data_ready_S(tx_ready[3]), .send_data_err_S(tx_err[3])
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    function automatic logic exp_par(input logic [15:0] w);
`ifdef PCSS_PARITY_EN
        return ^w;
`else
        return 1'b0;
`endif
    endfunction

    // Packet-level model of the tile
    function automatic void push_pkt(input int port, input logic [63:0] pkt);
        for (int w = 0; w < 4; w++) exp_q[port].push_back(pkt[63-16*w -: 16]);
    endfunction

    function automatic void model_pkt(input logic [63:0] pkt);
        logic [1:0] kind;
        logic [2:0] route;
        kind  = pkt[63:62];
        route = pkt[61:59];
        if (kind[1]) return;
        if (route == 3'd0) begin
            if (kind == 2'b01) m_tbl[pkt[51:48]] = pkt[47:0];
            else m_pend[pkt[3:0]] = 1'b1;
        end else if (route <= 3'd4) begin
            push_pkt(int'(route) - 1, {kind, 3'b000, pkt[58:0]});
        end
    endfunction

    function automatic void model_tik();
        logic [2:0] r;
        for (int i = 0; i < 16; i++) begin
            if (m_pend[i]) begin
                m_pend[i] = 1'b0;
                r = m_tbl[i][46:44];
                if (m_tbl[i][47] && r >= 3'd1 && r <= 3'd4)
                    push_pkt(int'(r) - 1, {2'b00, r, 15'b0, m_tbl[i][43:0]});
            end
        end
    endfunction

    // Compare process: far side of every send link, checked against the model every cycle.
    logic        inject;
    logic [15:0] w_exp;
    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (!rst_n) begin
                chk("reset_outputs", {44'b0, tx_valid[p], tx_par[p], tx_data[p], rx_ready[p], rx_err[p]}, 64'd0);
                tx_ready[p] = 1'b0;
                tx_err[p]   = 1'b0;
            end else if (!tx_ready[p] && tx_valid[p]) begin
                inject = 1'b0;
                if (exp_q[p].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word port %0d: got %h, required no word", p, tx_data[p]);
                end else begin
                    w_exp = exp_q[p][0];
                    chk($sformatf("send_word_p%0d", p), {48'b0, tx_data[p]}, {48'b0, w_exp});
                    chk($sformatf("send_par_p%0d", p), {63'b0, tx_par[p]}, {63'b0, exp_par(w_exp)});
                    if (inj_armed && p == inj_port && (got_total[p] % 4) == inj_word) begin
                        inject    = 1'b1;
                        inj_armed = 1'b0;
                        inj_hits++;
                        inj_seen  = tx_data[p];
                    end else begin
                        void'(exp_q[p].pop_front());
                        got_q[p].push_back(tx_data[p]);
                        got_total[p]++;
                    end
                end
                tx_ready[p] = 1'b1;
                tx_err[p]   = inject;
            end else if (tx_ready[p] && !tx_valid[p]) begin
                tx_ready[p] = 1'b0;
                tx_err[p]   = 1'b0;
            end
        end
    end

    // Driver: one packet on a receive link; bad_word gets wrong parity and ends the packet there.
    task automatic send_pkt(input int port, input logic [63:0] pkt, input int bad_word);
        logic [15:0] word;
        logic        exp_err;
        int          n;
        for (int w = 0; w < 4; w++) begin
            word = pkt[63-16*w -: 16];
            @(negedge clk);
            rx_data[port]  = word;
            rx_par[port]   = (^word) ^ (w == bad_word);
            rx_valid[port] = 1'b1;
            n = 0;
            while (!rx_ready[port] && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!rx_ready[port]) begin
                n_tests++;
                n_fail++;
                $display("FAIL recv_ready_timeout port %0d word %0d: got ready 0, required 1", port, w);
                rx_valid[port] = 1'b0;
                return;
            end
`ifdef PCSS_PARITY_EN
            exp_err = (w == bad_word);
`else
            exp_err = 1'b0;
`endif
            chk($sformatf("recv_err_p%0d_w%0d", port, w), {63'b0, rx_err[port]}, {63'b0, exp_err});
            rx_valid[port] = 1'b0;
            n = 0;
            @(negedge clk);
            while (rx_ready[port] && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (rx_ready[port]) begin
                n_tests++;
                n_fail++;
                $display("FAIL recv_release_timeout port %0d word %0d: got ready 1, required 0", port, w);
                return;
            end
            if (w == bad_word) return;
        end
    endtask

    task automatic toggle_tik();
        @(negedge clk);
        tik = ~tik;
        model_tik();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic check_log(input string name, input int port, input int base, input logic [63:0] pkt);
        chk({name, "_count"}, 64'(got_q[port].size() >= base + 4), 64'd1);
        for (int w = 0; w < 4; w++) begin
            if (got_q[port].size() > base + w)
                chk($sformatf("%s_w%0d", name, w), {48'b0, got_q[port][base+w]}, {48'b0, pkt[63-16*w -: 16]});
        end
    endtask

    task automatic clear_logs();
        for (int p = 0; p < 4; p++) got_q[p].delete();
    endtask

    initial begin
        for (int p = 0; p < 4; p++) begin
            rx_data[p]   = '0;
            rx_valid[p]  = 1'b0;
            rx_par[p]    = 1'b0;
            tx_ready[p]  = 1'b0;
            tx_err[p]    = 1'b0;
            got_total[p] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            m_tbl[i]  = '0;
            m_pend[i] = 1'b0;
        end

        // Reset: outputs checked every cycle by the compare process while rst_n is low
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        for (int p = 0; p < 4; p++)
            chk($sformatf("post_reset_p%0d", p),
                {60'b0, tx_valid[p], rx_ready[p], rx_err[p], tx_par[p]}, 64'd0);

        // Config entry 3 -> E, then spike 3; nothing leaves before the tik edge
        model_pkt(64'h4003_9000_0000_0ABC);
        send_pkt(0, 64'h4003_9000_0000_0ABC, -1);
        model_pkt(64'h0000_0000_0000_0003);
        send_pkt(0, 64'h0000_0000_0000_0003, -1);
        repeat (20) @(negedge clk);
        chk("no_output_before_tik", 64'(got_total[0] + got_total[1] + got_total[2] + got_total[3]), 64'd0);
        toggle_tik();
        drain();
        check_log("spike_fanout", 0, 0, 64'h0800_0000_0000_0ABC);
        chk("spike_fanout_once", 64'(got_q[0].size()), 64'd4);
        clear_logs();

        // Forward W -> N with route cleared
        model_pkt(64'h1000_0000_0000_1234);
        send_pkt(2, 64'h1000_0000_0000_1234, -1);
        drain();
        check_log("forward_wn", 1, 0, 64'h0000_0000_0000_1234);
        clear_logs();

`ifdef PCSS_PARITY_EN
        // Corrupted second word drops the packet; the next clean one routes E -> W
        send_pkt(0, 64'h2000_0000_0000_DEAD, 1);
        model_pkt(64'h1800_0000_0000_5555);
        send_pkt(0, 64'h1800_0000_0000_5555, -1);
        drain();
        chk("parity_drop_s", 64'(got_q[3].size()), 64'd0);
        check_log("parity_recover", 2, 0, 64'h0000_0000_0000_5555);
        clear_logs();
`endif

        // Far side rejects word 3 of an N -> E forward once
        inj_port  = 0;
        inj_word  = 2;
        inj_armed = 1'b1;
        model_pkt(64'h0800_1111_2222_3333);
        send_pkt(1, 64'h0800_1111_2222_3333, -1);
        drain();
        chk("send_err_hits", 64'(inj_hits), 64'd1);
        chk("send_err_word", {48'b0, inj_seen}, 64'h2222);
        check_log("send_err_resend", 0, 0, 64'h0000_1111_2222_3333);
        clear_logs();

        // E and N both forward to S in the same cycle: E goes first
        model_pkt(64'h2000_0000_0000_00E1);
        model_pkt(64'h2000_0000_0000_00A2);
        fork
            send_pkt(0, 64'h2000_0000_0000_00E1, -1);
            send_pkt(1, 64'h2000_0000_0000_00A2, -1);
        join
        drain();
        check_log("contend_first", 3, 0, 64'h0000_0000_0000_00E1);
        check_log("contend_second", 3, 4, 64'h0000_0000_0000_00A2);
        clear_logs();

        // Unconfigured, invalid and bad-route entries are skipped; valid ones still fire
        model_pkt(64'h4002_C000_0000_0123);
        send_pkt(2, 64'h4002_C000_0000_0123, -1);
        model_pkt(64'h4006_1000_0000_0777);
        send_pkt(2, 64'h4006_1000_0000_0777, -1);
        model_pkt(64'h4007_D000_0000_0001);
        send_pkt(2, 64'h4007_D000_0000_0001, -1);
        for (int i = 2; i < 8; i++) begin
            if (i != 4) begin
                model_pkt(64'(i));
                send_pkt(2, 64'(i), -1);
            end
        end
        repeat (10) @(negedge clk);
        toggle_tik();
        drain();
        check_log("walk_e", 0, 0, 64'h0800_0000_0000_0ABC);
        check_log("walk_s", 3, 0, 64'h2000_0000_0000_0123);
        chk("walk_total", 64'(got_q[0].size() + got_q[1].size() + got_q[2].size() + got_q[3].size()), 64'd8);
        clear_logs();

        for (int p = 0; p < 4; p++)
            chk($sformatf("final_exp_empty_p%0d", p), 64'(exp_q[p].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pcss_top.md
Name: pcss_top

Overview:
- Chip-level top of one PCSS neuromorphic tile. Four chip-to-chip links (E, N, W, S); each link is a 16-bit, parity-protected, four-phase receive/send pair.
- Incoming 64-bit packets are either configuration writes, local spikes, or transit packets forwarded to another link.
- Local spikes are latched and, on each tik edge, expanded through a fan-out table into outgoing spike packets.

Parameters:
- FW, 59: payload field width; FW+CONNECT_WIDTH is the packet width and must equal 64.
- B, 4: neuron index width; fan-out table has 2^B entries.
- CONNECT, 2: connection count. Reserved; no effect.
- CONNECT_WIDTH, 5: connection field width (packet = FW+CONNECT_WIDTH bits).
- P_MESH, 5: mesh port count. Reserved; no effect.
- P_HIER, 7: hierarchy port count. Reserved; no effect.
- CHIPDATA_WIDTH, 16: link word width; packet = 4 words.

Ports (d = E, N, W, S; each d port is repeated per side):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tik  in  1  time-step toggle; both edges are time-step boundaries
- recv_data_in_d  in  16  incoming word
- recv_data_valid_d  in  1  incoming word valid
- recv_data_par_d  in  1  XOR-reduce of recv_data_in_d
- recv_data_ready_d  out  1  word accepted
- recv_data_err_d  out  1  parity error on the accepted word
- send_data_out_d  out  16  outgoing word
- send_data_valid_d  out  1  outgoing word valid
- send_data_par_d  out  1  XOR-reduce of send_data_out_d
- send_data_ready_d  in  1  far side accepted word
- send_data_err_d  in  1  far side parity error; resend word

Behaviour:
- Reset: all outputs 0; word counters 0; fan-out table invalid; pending vector 0; buffers empty.
- Packet bit fields, first word = bits [63:48]:
  - [63:62] kind: 00 spike, 01 config write, 10/11 dropped.
  - [61:59] route: 0 local, 1 E, 2 N, 3 W, 4 S, 5-7 dropped.
- Receive, four-phase, per port:
  - When valid=1 and ready=0 and the assembly register is free: capture the word and set ready=1.
  - Hold ready=1 until valid=0, then clear ready the next cycle.
  - err is driven together with ready: err = (par != ^data).
  - A parity error discards the partial packet and resets that port's word counter to 0.
  - After the 4th good word the packet is pending. The port accepts no new word until the arbiter consumes the packet (backpressure by withholding ready).
- Arbiter: at most one packet per cycle, fixed priority E > N > W > S > local generator. A packet is taken only if its target send buffer is free or it needs no send buffer.
  - Route 0, kind 01 (config): table[pkt[B+47:48]] <= pkt[47:0].
    - Entry [47] valid, [46:44] out route, [43:0] payload.
  - Route 0, kind 00 (spike): pending[pkt[B-1:0]] <= 1.
  - Route 1-4: forward to that send buffer with route cleared to 000; all other bits unchanged.
- Spike generator:
  - On detection of a tik edge (registered tik differs from tik), snapshot pending into a work vector and clear pending.
  - A spike arriving in the same cycle as the edge goes to the next step.
  - Walk set bits from lowest index upward. For a valid entry with route 1-4, offer {2'b00, route, 15'b0, payload} to that send buffer. Invalid entries and bad routes are skipped.
  - A new tik edge while the walk is unfinished ORs the new snapshot into the remaining work.
- Send, per port, one 64-bit buffer, words MSB first:
  - Drive data, par, valid=1.
  - On ready=1: valid <= 0. If err=1 at that moment, the same word is resent; otherwise advance.
  - Wait for ready=0 before presenting the next word.
  - The buffer frees after the 4th word handshake.
- Reset mid-transfer aborts all transfers immediately.

Optional Feature:
- PCSS_PARITY_EN defined: receive parity is checked and err behaves as above; send_data_par is generated.
- Undefined: recv_data_err_d is tied 0, received parity is ignored, send_data_par_d is tied 0.

Test Plan:
- Reset: during and after rst_n low, every output is 0 and no send valid is raised before stimulus.
- Config then spike: on E, send 64'h4003_9000_0000_0ABC, then spike 64'h0000_0000_0000_0003; toggle tik. Send E emits words 0800, 0000, 0000, 0ABC exactly once. No output appears before the tik edge.
- Forward: send 64'h1000_0000_0000_1234 on W. Send N emits 0000, 0000, 0000, 1234 with correct parity on each word.
- Parity error (PCSS_PARITY_EN): corrupt recv_data_par_E on word 2. recv_data_err_E=1 with ready; that packet produces no output. The next clean packet processes normally.
- Send-side error: assert send_data_err_E on word 3. The same word is repeated, then word 4 is sent; the packet completes.
- Contention and undefined entries: simultaneous E and N forwards to S are serialized E first. A spike on an invalid table entry produces no output.
